i2s_audio_rx: RTL and testbench

//  Parametrised I2S master-mode receiver. Derives AUD_BCK/AUD_LRCK from AUD_XCK.

---
 rtl/i2s_audio_rx.sv | 151 +++++++++++++++
 tb/tb_i2s_audio_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_rx.sv
// I2S / left-justified master-mode receiver: generates BCK/LRCK from XCK, deserialises
// both channels and hands each stereo frame out over a one-deep valid/ready stage.
module i2s_audio_rx #(
  parameter int unsigned BCK_DIV   = 3,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned I2S_MODE  = 1
) (
  input  logic              AUD_XCK,
  input  logic              reset,
  input  logic              en,
  input  logic              AUD_DATA,
  output logic              AUD_BCK,
  output logic              AUD_LRCK,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned OFS   = (I2S_MODE != 0) ? 1 : 0;
  localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(SLOT_BITS);

  if (BCK_DIV < 1) begin : g_chk_div
    $error("BCK_DIV must be at least 1");
  end
  if (SLOT_BITS < 8 || SLOT_BITS > 64) begin : g_chk_slot
    $error("SLOT_BITS must be in 8..64");
  end
  if (DATA_W < 2 || DATA_W + OFS > SLOT_BITS) begin : g_chk_data
    $error("DATA_W plus data offset must fit in SLOT_BITS");
  end

  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_bck;
  logic              r_lrck;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_left_hold;
  logic [DATA_W-1:0] r_right_hold;
  logic              r_left_ok;
  logic              r_frame_done;
  logic [DATA_W-1:0] r_out_left;
  logic [DATA_W-1:0] r_out_right;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_tc;
  logic              w_rise;
  logic              w_fall;
  logic [BIT_W-1:0]  w_rel;
  logic              w_in_win;
  logic              w_last;
  logic [DATA_W-1:0] w_word;
  logic              w_ovr_set;

  assign w_tc   = (r_div_cnt == DIV_W'(BCK_DIV - 1));
  assign w_rise = w_tc & ~r_bck;
  assign w_fall = w_tc & r_bck;

  // Position within the data window; bit_cnt below OFS wraps to a large value.
  assign w_rel     = r_bit_cnt - BIT_W'(OFS);
  assign w_in_win  = ({1'b0, w_rel} < (BIT_W + 1)'(DATA_W));
  assign w_last    = (w_rel == BIT_W'(DATA_W - 1));
  assign w_word    = {r_shreg[DATA_W-2:0], AUD_DATA};
  assign w_ovr_set = r_frame_done & r_out_valid & ~out_ready;

  always_ff @(posedge AUD_XCK or posedge reset) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_bck        <= 1'b0;
      r_lrck       <= 1'b0;
      r_shreg      <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
      r_left_ok    <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_left   <= '0;
      r_out_right  <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!en) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_bck     <= 1'b0;
        r_lrck    <= 1'b0;
        r_shreg   <= '0;
        r_left_ok <= 1'b0;
      end else begin
        if (w_tc) begin
          r_div_cnt <= '0;
          r_bck     <= ~r_bck;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
        if (w_fall) begin
          if (r_bit_cnt == BIT_W'(SLOT_BITS - 1)) begin
            r_bit_cnt <= '0;
            r_lrck    <= ~r_lrck;
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        if (w_rise && w_in_win) begin
          r_shreg <= w_word;
          if (w_last) begin
            if (!r_lrck) begin
              r_left_hold <= w_word;
              r_left_ok   <= 1'b1;
            end else if (r_left_ok) begin
              r_right_hold <= w_word;
              r_frame_done <= 1'b1;
              r_left_ok    <= 1'b0;
            end
          end
        end
      end

      // Output stage keeps running while disabled so a held frame can still drain.
      if (r_frame_done) begin
        if (!r_out_valid || out_ready) begin
          r_out_left  <= r_left_hold;
          r_out_right <= r_right_hold;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign AUD_BCK   = r_bck;
  assign AUD_LRCK  = r_lrck;
  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Directed bench for i2s_audio_rx: an I2S instance (defaults) and a left-justified
// 24-bit instance, each fed by a small codec model driving data after BCK falls.
module tb_i2s_audio_rx;

  logic        xck = 1'b0;
  logic        rst;
  logic        en;
  logic        d_a, d_b;
  logic        rdy_a, rdy_b, clr_a, clr_b;
  logic        bck_a, lrck_a, vld_a, ovr_a;
  logic        bck_b, lrck_b, vld_b, ovr_b;
  logic [15:0] l_a, r_a;
  logic [23:0] l_b, r_b;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;
  int fbase = 0;

  logic [15:0] l_tab [8];
  logic [15:0] r_tab [8];
  logic [23:0] lj_l = 24'hABCDEF;
  logic [23:0] lj_r = 24'h123456;

  i2s_audio_rx dut_a (
    .AUD_XCK    (xck),
    .reset      (rst),
    .en         (en),
    .AUD_DATA   (d_a),
    .AUD_BCK    (bck_a),
    .AUD_LRCK   (lrck_a),
    .out_left   (l_a),
    .out_right  (r_a),
    .out_valid  (vld_a),
    .out_ready  (rdy_a),
    .overrun    (ovr_a),
    .overrun_clr(clr_a)
  );

  i2s_audio_rx #(
    .BCK_DIV  (3),
    .SLOT_BITS(32),
    .DATA_W   (24),
    .I2S_MODE (0)
  ) dut_b (
    .AUD_XCK    (xck),
    .reset      (rst),
    .en         (en),
    .AUD_DATA   (d_b),
    .AUD_BCK    (bck_b),
    .AUD_LRCK   (lrck_b),
    .out_left   (l_b),
    .out_right  (r_b),
    .out_valid  (vld_b),
    .out_ready  (rdy_b),
    .overrun    (ovr_b),
    .overrun_clr(clr_b)
  );

  always #5 xck = ~xck;

  // XCK edges since en rose; edge 1 is the first edge that sees en=1.
  always @(posedge xck) begin
    if (en) ecnt <= ecnt + 1;
    else    ecnt <= 0;
  end

  function automatic logic get_bit(logic [63:0] w, int dw, int ofs, int pos, logic pad);
    if (pos >= ofs && pos < ofs + dw) return w[dw-1-(pos-ofs)];
    return pad;
  endfunction

  int   pos_a = 0, fi_a = 0, pos_b = 0;
  logic pb_a = 1'b0, pl_a = 1'b0, pb_b = 1'b0, pl_b = 1'b0;

  always @(negedge xck) begin
    if (!en) begin
      pos_a = 0; fi_a = 0; pb_a = 1'b0; pl_a = 1'b0;
    end else begin
      if (pb_a && !bck_a) begin
        if (lrck_a != pl_a) pos_a = 0;
        else                pos_a = pos_a + 1;
        if (pl_a && !lrck_a) fi_a = fi_a + 1;
      end
      pb_a = bck_a; pl_a = lrck_a;
    end
    d_a = get_bit(lrck_a ? 64'(r_tab[(fbase + fi_a) % 8]) : 64'(l_tab[(fbase + fi_a) % 8]),
                  16, 1, pos_a, 1'b0);
  end

  always @(negedge xck) begin
    if (!en) begin
      pos_b = 0; pb_b = 1'b0; pl_b = 1'b0;
    end else begin
      if (pb_b && !bck_b) begin
        if (lrck_b != pl_b) pos_b = 0;
        else                pos_b = pos_b + 1;
      end
      pb_b = bck_b; pl_b = lrck_b;
    end
    d_b = get_bit(lrck_b ? 64'(lj_r) : 64'(lj_l), 24, 0, pos_b, 1'b1);
  end

  task automatic wait_edge(input int n);
    int k = 0;
    while (ecnt < n && k < 5000) begin
      @(posedge xck); #1;
      k++;
    end
    if (ecnt < n) begin
      n_bad++;
      $display("FAIL wait_edge: reached edge %0d, required %0d", ecnt, n);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bck_a !== 1'b0) begin n_bad++; $display("FAIL reset_bck: got %b want 0", bck_a); end
    n_cmp++; if (lrck_a !== 1'b0) begin n_bad++; $display("FAIL reset_lrck: got %b want 0", lrck_a); end
    n_cmp++; if (l_a !== 16'h0) begin n_bad++; $display("FAIL reset_left: got %h want 0", l_a); end
    n_cmp++; if (r_a !== 16'h0) begin n_bad++; $display("FAIL reset_right: got %h want 0", r_a); end
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", vld_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
  endtask

  task automatic test_dividers();
    wait_edge(2);
    n_cmp++; if (bck_a !== 1'b0) begin n_bad++; $display("FAIL div_bck_e2: got %b want 0", bck_a); end
    wait_edge(3);
    n_cmp++; if (bck_a !== 1'b1) begin n_bad++; $display("FAIL div_bck_e3: got %b want 1", bck_a); end
    wait_edge(6);
    n_cmp++; if (bck_a !== 1'b0) begin n_bad++; $display("FAIL div_bck_e6: got %b want 0", bck_a); end
    wait_edge(9);
    n_cmp++; if (bck_a !== 1'b1) begin n_bad++; $display("FAIL div_bck_e9: got %b want 1", bck_a); end
    wait_edge(191);
    n_cmp++; if (lrck_a !== 1'b0) begin n_bad++; $display("FAIL div_lrck_e191: got %b want 0", lrck_a); end
    wait_edge(192);
    n_cmp++; if (lrck_a !== 1'b1) begin n_bad++; $display("FAIL div_lrck_e192: got %b want 1", lrck_a); end
  endtask

  task automatic test_i2s_capture();
    wait_edge(291);
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL i2s_early_valid: got %b want 0", vld_a); end
    wait_edge(293);
    n_cmp++; if (vld_a !== 1'b1) begin n_bad++; $display("FAIL i2s_valid: got %b want 1", vld_a); end
    n_cmp++; if (l_a !== 16'h8001) begin n_bad++; $display("FAIL i2s_left: got %h want 8001", l_a); end
    n_cmp++; if (r_a !== 16'h7FFE) begin n_bad++; $display("FAIL i2s_right: got %h want 7ffe", r_a); end
  endtask

  task automatic test_left_justified();
    wait_edge(333);
    n_cmp++; if (vld_b !== 1'b0) begin n_bad++; $display("FAIL lj_early_valid: got %b want 0", vld_b); end
    wait_edge(335);
    n_cmp++; if (vld_b !== 1'b1) begin n_bad++; $display("FAIL lj_valid: got %b want 1", vld_b); end
    n_cmp++; if (l_b !== 24'hABCDEF) begin n_bad++; $display("FAIL lj_left: got %h want abcdef", l_b); end
    n_cmp++; if (r_b !== 24'h123456) begin n_bad++; $display("FAIL lj_right: got %h want 123456", r_b); end
  endtask

  task automatic test_backpressure();
    wait_edge(680);
    n_cmp++; if (l_a !== 16'h8001) begin n_bad++; $display("FAIL bp_left_held: got %h want 8001", l_a); end
    n_cmp++; if (r_a !== 16'h7FFE) begin n_bad++; $display("FAIL bp_right_held: got %h want 7ffe", r_a); end
    n_cmp++; if (vld_a !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", vld_a); end
    n_cmp++; if (ovr_a !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b want 1", ovr_a); end
    clr_a = 1'b1;
    wait_edge(681);
    clr_a = 1'b0;
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL bp_overrun_clr: got %b want 0", ovr_a); end
    rdy_a = 1'b1;
    wait_edge(682);
    rdy_a = 1'b0;
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL bp_accept_valid: got %b want 0", vld_a); end
    n_cmp++; if (l_a !== 16'h8001) begin n_bad++; $display("FAIL bp_accept_hold: got %h want 8001", l_a); end
  endtask

  task automatic test_back_to_back();
    wait_edge(1062);
    n_cmp++; if (vld_a !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2: got %b want 1", vld_a); end
    n_cmp++; if (l_a !== 16'hA5A5) begin n_bad++; $display("FAIL b2b_left2: got %h want a5a5", l_a); end
    wait_edge(1443);
    rdy_a = 1'b1;
    wait_edge(1444);
    rdy_a = 1'b0;
    n_cmp++; if (vld_a !== 1'b1) begin n_bad++; $display("FAIL b2b_valid3: got %b want 1", vld_a); end
    n_cmp++; if (l_a !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_left3: got %h want 0f0f", l_a); end
    n_cmp++; if (r_a !== 16'hF0F0) begin n_bad++; $display("FAIL b2b_right3: got %h want f0f0", r_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", ovr_a); end
  endtask

  task automatic test_en_disturb();
    rdy_a = 1'b1;
    wait_edge(1450);
    rdy_a = 1'b0;
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL en_drain: got %b want 0", vld_a); end
    wait_edge(1779);
    en = 1'b0;
    fbase = 5;
    repeat (30) @(posedge xck);
    #1;
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL en_broken_frame: got %b want 0", vld_a); end
    n_cmp++; if (bck_a !== 1'b0) begin n_bad++; $display("FAIL en_off_bck: got %b want 0", bck_a); end
    n_cmp++; if (lrck_a !== 1'b0) begin n_bad++; $display("FAIL en_off_lrck: got %b want 0", lrck_a); end
    en = 1'b1;
    wait_edge(291);
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL en_restart_early: got %b want 0", vld_a); end
    wait_edge(293);
    n_cmp++; if (vld_a !== 1'b1) begin n_bad++; $display("FAIL en_restart_valid: got %b want 1", vld_a); end
    n_cmp++; if (l_a !== 16'hC3C3) begin n_bad++; $display("FAIL en_restart_left: got %h want c3c3", l_a); end
    n_cmp++; if (r_a !== 16'h3C3C) begin n_bad++; $display("FAIL en_restart_right: got %h want 3c3c", r_a); end
  endtask

  task automatic test_reset_midframe();
    wait_edge(298);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bck_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bck: got %b want 0", bck_a); end
    n_cmp++; if (lrck_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_lrck: got %b want 0", lrck_a); end
    n_cmp++; if (vld_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", vld_a); end
    n_cmp++; if (l_a !== 16'h0) begin n_bad++; $display("FAIL mid_rst_left: got %h want 0", l_a); end
    n_cmp++; if (r_a !== 16'h0) begin n_bad++; $display("FAIL mid_rst_right: got %h want 0", r_a); end
    n_cmp++; if (vld_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_lj_valid: got %b want 0", vld_b); end
    n_cmp++; if (ovr_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_lj_overrun: got %b want 0", ovr_b); end
  endtask

  initial begin
    l_tab[0] = 16'h8001; r_tab[0] = 16'h7FFE;
    l_tab[1] = 16'h1234; r_tab[1] = 16'h4321;
    l_tab[2] = 16'hA5A5; r_tab[2] = 16'h5A5A;
    l_tab[3] = 16'h0F0F; r_tab[3] = 16'hF0F0;
    l_tab[4] = 16'hFFFF; r_tab[4] = 16'h0001;
    l_tab[5] = 16'hC3C3; r_tab[5] = 16'h3C3C;
    l_tab[6] = 16'h0000; r_tab[6] = 16'h0000;
    l_tab[7] = 16'h0000; r_tab[7] = 16'h0000;
    rst = 1'b1; en = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(posedge xck);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge xck);
    #1;
    en = 1'b1;
    test_dividers();
    test_i2s_capture();
    test_left_justified();
    test_backpressure();
    test_back_to_back();
    test_en_disturb();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
